subbytes: RTL and testbench
===========================

// Module: subbytes
// PURPOSE
// - AES SubBytes stage: applies the FIPS-197 forward S-box independently to each of the 16 bytes of a 128-bit state.
// - Sits in the AES round datapath between AddRoundKey and ShiftRows.
// - The output is registered, giving one clock of latency.
// - A valid flag travels alongside the data so the round controller can sequence stages.
// PARAMETERS
// - none. The S-box is fixed by FIPS-197 and there are always 16 bytes.
// PORTS
// - clk        input   1    system clock; all state updates on its rising edge
// - rst        input   1    synchronous, active-high reset
// - in_valid   input   1    state is valid this cycle
// - state      input   128  AES state; byte k occupies bits [127-8k -: 8], k=0..15
// - out        output  128  substituted state, same byte layout as state
// - out_valid  output  1    out holds the result for the state accepted on the previous cycle
// BEHAVIOUR
// - Reset:
//   - Clock and reset are a single clock with synchronous, active-high reset; there are no asynchronous paths.
//   - With rst=1 at a rising edge: out <= 128'h0 and out_valid <= 0.
//   - rst takes priority over in_valid.
// - Normal operation, each rising edge with rst=0:
//   - out[127-8k -: 8] <= SBOX[state[127-8k -: 8]] for every k=0..15.
//   - out_valid <= in_valid.
// - Latency is exactly 1 cycle. Throughput is one state per cycle, with no stall or backpressure.
// - out is updated every cycle, whether or not in_valid is high.
//   - Consumers qualify out with out_valid.
//   - out never holds X after reset.
// - SBOX is the standard AES forward table, with no inverse mode.
//   - Spot values: 00->63, 01->7C, 0F->76, 53->ED, FF->16.
// - All 16 lookups are purely combinational, and bytes never interact.
// - Reset asserted mid-stream drops the in-flight result: out_valid=0 on the next cycle.
// - Back-to-back valid inputs produce back-to-back valid outputs in the same order.
// STRUCTURE
// - Shared package aes_pkg:
//   - localparam AES_SBOX: a 256x8 table, constant-indexable.
//   - typedef aes_state_t = logic [127:0].
//   - typedef aes_byte_t = logic [7:0].
// - Sub-module aes_sbox: 8-bit in, 8-bit out, combinational, a full 256-entry case ROM.
//   - subbytes instantiates it 16 times through a generate loop.
//   - A single output register bank plus the valid flop follow the 16 instances.
// TESTING
// - Reset test:
//   - Hold rst=1 for 2 cycles with in_valid=1 and state=any.
//   - Required: out=0 and out_valid=0 throughout.
// - Ordered bytes:
//   - Drive state=000102030405060708090A0B0C0D0E0F with in_valid=1.
//   - Required, one cycle later: out=637C777BF26B6FC53001672BFED7AB76 and out_valid=1.
// - Corner values:
//   - state=all 00 -> out=all 63.
//   - state=all FF -> out=all 16.
//   - state=all 53 -> out=all ED.
// - FIPS-197 Appendix B, round 1:
//   - state=193DE3BEA0F4E22B9AC68D2AE9F84808 -> out=D42711AEE0BF98F1B8B45DE51E415230.
// - Streaming:
//   - Drive the ordered, corner and FIPS vectors on consecutive cycles, then deassert in_valid.
//   - Required: outputs arrive in the same order with 1-cycle latency, then out_valid drops.
//   - Finish with an exhaustive sweep of each byte value 00..FF in every lane against a reference S-box model.
// - Mid-stream reset:
//   - Assert rst for 1 cycle during a valid stream.
//   - Required: the next cycle shows out=0 and out_valid=0; the following valid input resumes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types and the forward S-box table.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  // Forward S-box, index 0 first; constant-indexable for elaboration-time use.
  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box as a combinational 256-entry case ROM.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  output aes_byte_t out_byte
);

  // Table lookup; the case is complete, the leading default only keeps the block latch-free.
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b;
      8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b;
      8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d;
      8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf;
      8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26;
      8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1;
      8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3;
      8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2;
      8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a;
      8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3;
      8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed;
      8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39;
      8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb;
      8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f;
      8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f;
      8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21;
      8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec;
      8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d;
      8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc;
      8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14;
      8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a;
      8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62;
      8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d;
      8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea;
      8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e;
      8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f;
      8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66;
      8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9;
      8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11;
      8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9;
      8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d;
      8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f;
      8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
    endcase
  end

endmodule

// File: rtl/subbytes.sv
// AES SubBytes stage: 16 parallel S-box lookups feeding one output register bank.
module subbytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] state,
  output logic [127:0] out,
  output logic         out_valid
);

  aes_state_t sub_next;
  aes_state_t out_reg;
  logic       out_valid_reg;

  // One combinational S-box per byte lane; lanes are fully independent.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gen_lane
      aes_sbox u_sbox (
        .in_byte  (state[127-8*gi -: 8]),
        .out_byte (sub_next[127-8*gi -: 8])
      );
    end
  endgenerate

  // Capture the substituted state every cycle; valid rides alongside, reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_reg       <= sub_next;
      out_valid_reg <= in_valid;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_subbytes.sv
// Directed self-checking bench for subbytes, with an algorithmic S-box reference for the lane sweep.
module tb_subbytes;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] state;
  logic [127:0] out;
  logic         out_valid;

  int n_vec;
  int n_err;

  subbytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .state     (state),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference S-box: multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, sq, b, s;
    inv = 8'h01; sq = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    b = (a == 8'h00) ? 8'h00 : inv;
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_ref(s[127-8*k -: 8]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Apply inputs, advance one rising edge, settle just after it.
  task automatic step(input logic r, input logic v, input logic [127:0] s);
    rst = r; in_valid = v; state = s;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V_ORD  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] E_ORD  = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] V_Z    = 128'h00000000000000000000000000000000;
  localparam logic [127:0] E_Z    = 128'h63636363636363636363636363636363;
  localparam logic [127:0] V_F    = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [127:0] E_F    = 128'h16161616161616161616161616161616;
  localparam logic [127:0] V_53   = 128'h53535353535353535353535353535353;
  localparam logic [127:0] E_53   = 128'hEDEDEDEDEDEDEDEDEDEDEDEDEDEDEDED;
  localparam logic [127:0] V_FIPS = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
  localparam logic [127:0] E_FIPS = 128'hD42711AEE0BF98F1B8B45DE51E415230;

  initial begin
    logic [127:0] sv;
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b1; state = V_ORD;
    @(negedge clk);

    // Reset held two cycles with valid input present.
    step(1'b1, 1'b1, V_ORD);
    check("rst1_out", out, 128'h0); check_bit("rst1_valid", out_valid, 1'b0);
    step(1'b1, 1'b1, V_FIPS);
    check("rst2_out", out, 128'h0); check_bit("rst2_valid", out_valid, 1'b0);

    // Ordered bytes; output must not move before the edge.
    rst = 1'b0; in_valid = 1'b1; state = V_ORD;
    #2;
    check("ord_pre_edge", out, 128'h0);
    @(posedge clk); #1;
    check("ord_out", out, E_ORD); check_bit("ord_valid", out_valid, 1'b1);
    step(1'b0, 1'b0, V_Z);
    check_bit("idle_valid", out_valid, 1'b0);
    check("idle_out_updates", out, E_Z);

    // Streaming: ordered, corners, FIPS back to back, then valid drops.
    step(1'b0, 1'b1, V_ORD);  check("s_ord", out, E_ORD);   check_bit("s_ord_v", out_valid, 1'b1);
    step(1'b0, 1'b1, V_Z);    check("s_z", out, E_Z);       check_bit("s_z_v", out_valid, 1'b1);
    step(1'b0, 1'b1, V_F);    check("s_ff", out, E_F);      check_bit("s_ff_v", out_valid, 1'b1);
    step(1'b0, 1'b1, V_53);   check("s_53", out, E_53);     check_bit("s_53_v", out_valid, 1'b1);
    step(1'b0, 1'b1, V_FIPS); check("s_fips", out, E_FIPS); check_bit("s_fips_v", out_valid, 1'b1);
    step(1'b0, 1'b0, V_ORD);  check("s_end", out, E_ORD);   check_bit("s_end_v", out_valid, 1'b0);

    // Mid-stream reset drops the in-flight result, then resumes.
    step(1'b0, 1'b1, V_53);   check("m_53", out, E_53);     check_bit("m_53_v", out_valid, 1'b1);
    step(1'b1, 1'b1, V_FIPS); check("m_rst", out, 128'h0);  check_bit("m_rst_v", out_valid, 1'b0);
    step(1'b0, 1'b1, V_FIPS); check("m_resume", out, E_FIPS); check_bit("m_resume_v", out_valid, 1'b1);

    // Sweep: lane k carries (v+k) so every value visits every lane.
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 16; k++) sv[127-8*k -: 8] = 8'(v + k);
      step(1'b0, 1'b1, sv);
      check($sformatf("sweep_%02x", v), out, sub_ref(sv));
    end
    step(1'b0, 1'b0, V_Z);
    check_bit("sweep_end_v", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
